// File: rtl/memory_unit_queued.sv
// memory_unit_queued: in-order load/store request queue with a single outstanding load.
// Define MEM_UNIT_PERF_EN to enable the load/store/stall performance counters.
module memory_unit_queued #(
   parameter int CORE = 0,
   parameter int DATA_WIDTH = 32,
   parameter int ADDRESS_BITS = 20,
   parameter int DEPTH = 4
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      load,
   input  logic                      store,
   input  logic [ADDRESS_BITS-1:0]   address,
   input  logic [DATA_WIDTH-1:0]     store_data,
   input  logic [DATA_WIDTH/8-1:0]   byte_en,
   output logic                      ready,
   output logic                      mem_req_valid,
   output logic                      mem_req_write,
   output logic [ADDRESS_BITS-1:0]   mem_req_addr,
   output logic [DATA_WIDTH-1:0]     mem_req_data,
   output logic [DATA_WIDTH/8-1:0]   mem_req_be,
   input  logic                      mem_req_ready,
   input  logic                      mem_resp_valid,
   input  logic [DATA_WIDTH-1:0]     mem_resp_data,
   output logic                      valid,
   output logic [ADDRESS_BITS-1:0]   data_addr,
   output logic [DATA_WIDTH-1:0]     load_data,
   output logic [31:0]               load_count,
   output logic [31:0]               store_count,
   output logic [31:0]               stall_count
);
   localparam int PW = $clog2(DEPTH);
   localparam int BW = DATA_WIDTH / 8;

   if (DATA_WIDTH % 8 != 0 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CORE < 0) begin : g_invalid
      $error("memory_unit_queued: invalid parameters");
   end

   logic [ADDRESS_BITS-1:0] addr_q [DEPTH];
   logic [DATA_WIDTH-1:0]   data_q [DEPTH];
   logic [BW-1:0]           be_q   [DEPTH];
   logic [DEPTH-1:0]        write_q;
   logic [PW-1:0]           head, tail;
   logic [PW:0]             occupancy;
   logic                    load_pending;
   logic [ADDRESS_BITS-1:0] pending_addr;
   logic                    push, pop;

   assign ready         = reset & (occupancy < (PW+1)'(DEPTH));
   assign push          = (load | store) & ready;
   // A pending load blocks the head so program order is never violated.
   assign mem_req_valid = reset & (occupancy != '0) & ~load_pending;
   assign pop           = mem_req_valid & mem_req_ready;
   assign mem_req_write = write_q[head];
   assign mem_req_addr  = addr_q[head];
   assign mem_req_data  = data_q[head];
   assign mem_req_be    = be_q[head];

   always_ff @(posedge clock) begin
      if (push) begin
         addr_q[tail]  <= address;
         data_q[tail]  <= store_data;
         be_q[tail]    <= store ? byte_en : '0;
         write_q[tail] <= store;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         head         <= '0;
         tail         <= '0;
         occupancy    <= '0;
         load_pending <= 1'b0;
         pending_addr <= '0;
         valid        <= 1'b0;
         load_data    <= '0;
         data_addr    <= '0;
      end else begin
         head         <= head + PW'(pop);
         tail         <= tail + PW'(push);
         occupancy    <= occupancy + (PW+1)'(push) - (PW+1)'(pop);
         valid        <= load_pending & mem_resp_valid;
         load_pending <= pop ? ~write_q[head] : load_pending & ~mem_resp_valid;
         if (pop & ~write_q[head])
            pending_addr <= addr_q[head];
         if (load_pending & mem_resp_valid) begin
            load_data <= mem_resp_data;
            data_addr <= pending_addr;
         end
      end
   end

`ifdef MEM_UNIT_PERF_EN
   always_ff @(posedge clock) begin
      if (!reset) begin
         load_count  <= '0;
         store_count <= '0;
         stall_count <= '0;
      end else begin
         if (push & ~store & (load_count != '1))
            load_count <= load_count + 32'd1;
         if (push & store & (store_count != '1))
            store_count <= store_count + 32'd1;
         if ((load | store) & ~ready & (stall_count != '1))
            stall_count <= stall_count + 32'd1;
      end
   end
`else
   assign load_count  = '0;
   assign store_count = '0;
   assign stall_count = '0;
`endif
endmodule

// File: tb/tb_memory_unit_queued.sv
// tb_memory_unit_queued: randomized and directed stimulus against a queue-based reference model.
module tb_memory_unit_queued;
   localparam int D = 4;

   logic        clock = 1'b0, reset = 1'b0, load = 1'b0, store = 1'b0;
   logic [19:0] address = '0;
   logic [31:0] store_data = '0;
   logic [3:0]  byte_en = '0;
   logic        ready, mem_req_valid, mem_req_write;
   logic [19:0] mem_req_addr;
   logic [31:0] mem_req_data;
   logic [3:0]  mem_req_be;
   logic        mem_req_ready = 1'b0, mem_resp_valid = 1'b0;
   logic [31:0] mem_resp_data = '0;
   logic        valid;
   logic [19:0] data_addr;
   logic [31:0] load_data, load_count, store_count, stall_count;

   memory_unit_queued #(.CORE(0), .DATA_WIDTH(32), .ADDRESS_BITS(20), .DEPTH(D)) dut (
      .clock(clock), .reset(reset), .load(load), .store(store), .address(address),
      .store_data(store_data), .byte_en(byte_en), .ready(ready), .mem_req_valid(mem_req_valid),
      .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
      .mem_req_be(mem_req_be), .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
      .mem_resp_data(mem_resp_data), .valid(valid), .data_addr(data_addr), .load_data(load_data),
      .load_count(load_count), .store_count(store_count), .stall_count(stall_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        wr;
      logic [19:0] a;
      logic [31:0] d;
      logic [3:0]  be;
   } req_t;

   int checks = 0, failures = 0;
   req_t mq[$];
   logic        pend = 1'b0, exp_valid = 1'b0;
   logic [19:0] pend_addr = '0, exp_da = '0;
   logic [31:0] exp_ld = '0, m_lc = 0, m_sc = 0, m_stc = 0;

   function automatic void chk(string n, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", n, act, req, $time);
      end
   endfunction

   // Scoreboard: the model queue holds every accepted request; the DUT head must match its front.
   always @(negedge clock) begin
      logic e_ready, e_mrv, nxt_valid;
      req_t h;
      e_ready = reset && (mq.size() < D);
      e_mrv   = reset && (mq.size() != 0) && !pend;
      chk("valid", {31'd0, valid}, {31'd0, exp_valid});
      chk("load_data", load_data, exp_ld);
      chk("data_addr", {12'd0, data_addr}, {12'd0, exp_da});
      chk("ready", {31'd0, ready}, {31'd0, e_ready});
      chk("mem_req_valid", {31'd0, mem_req_valid}, {31'd0, e_mrv});
`ifdef MEM_UNIT_PERF_EN
      chk("load_count", load_count, m_lc);
      chk("store_count", store_count, m_sc);
      chk("stall_count", stall_count, m_stc);
`else
      chk("load_count", load_count, 32'd0);
      chk("store_count", store_count, 32'd0);
      chk("stall_count", stall_count, 32'd0);
`endif
      if (!reset) begin
         mq.delete();
         pend = 0; exp_valid = 0; exp_ld = '0; exp_da = '0;
         m_lc = 0; m_sc = 0; m_stc = 0;
      end else begin
         nxt_valid = 0;
         if (pend && mem_resp_valid) begin
            nxt_valid = 1; exp_ld = mem_resp_data; exp_da = pend_addr; pend = 0;
         end
         if (e_mrv) begin
            h = mq[0];
            chk("req_write", {31'd0, mem_req_write}, {31'd0, h.wr});
            chk("req_addr", {12'd0, mem_req_addr}, {12'd0, h.a});
            chk("req_be", {28'd0, mem_req_be}, {28'd0, h.be});
            if (h.wr) chk("req_data", mem_req_data, h.d);
            if (mem_req_ready) begin
               void'(mq.pop_front());
               if (!h.wr) begin pend = 1; pend_addr = h.a; end
            end
         end
         if ((load || store) && e_ready) begin
            mq.push_back('{wr: store, a: address, d: store_data, be: store ? byte_en : 4'h0});
            if (store) m_sc++; else m_lc++;
         end
         if ((load || store) && !e_ready) m_stc++;
         exp_valid = nxt_valid;
      end
   end

   task automatic drive(input logic l, s, input logic [19:0] a, input logic [31:0] d,
                        input logic [3:0] be, input logic mr, rv, input logic [31:0] rd);
      load = l; store = s; address = a; store_data = d; byte_en = be;
      mem_req_ready = mr; mem_resp_valid = rv; mem_resp_data = rd;
      @(posedge clock); #1;
   endtask

   task automatic idle(input int n, input logic mr);
      for (int i = 0; i < n; i++) drive(0, 0, '0, '0, '0, mr, 0, '0);
   endtask

   initial begin
      idle(2, 0);
      reset = 1;
      idle(1, 0);
      for (int i = 0; i < 5; i++) drive(0, 1, 20'(i), 32'hA000_0000 + i, 4'hF, 0, 0, '0);
      idle(2, 0);
      idle(6, 1);
      drive(1, 0, 20'h00100, '0, 4'hF, 1, 0, '0);
      idle(4, 1);
      drive(0, 0, '0, '0, '0, 1, 1, 32'hDEADBEEF);
      idle(2, 1);
      drive(1, 0, 20'h00200, '0, '0, 1, 0, '0);
      drive(0, 1, 20'h00204, 32'h1234_5678, 4'h3, 1, 0, '0);
      idle(5, 1);
      drive(0, 0, '0, '0, '0, 1, 1, 32'hCAFE_F00D);
      idle(3, 1);
      drive(1, 1, 20'h00040, 32'h5555_AAAA, 4'h9, 1, 0, '0);
      idle(2, 1);
      drive(1, 0, 20'h00300, '0, '0, 1, 0, '0);
      drive(0, 1, 20'h00304, 32'h1, 4'h1, 1, 0, '0);
      drive(0, 1, 20'h00308, 32'h2, 4'h2, 0, 0, '0);
      drive(0, 1, 20'h0030C, 32'h3, 4'h4, 0, 0, '0);
      reset = 0;
      idle(1, 0);
      reset = 1;
      drive(0, 0, '0, '0, '0, 0, 1, 32'hBAD0_BAD0);
      idle(2, 1);
      for (int i = 0; i < 8; i++) drive(0, 1, 20'(i), 32'(i * 3), 4'hF, 1, 0, '0);
      idle(3, 1);
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 199) != 0);
         drive($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, 20'($urandom),
               $urandom, 4'($urandom), $urandom_range(0, 1) == 1,
               $urandom_range(0, 2) == 0, $urandom);
      end
      reset = 1;
      idle(10, 1);
      drive(0, 0, '0, '0, '0, 1, 1, 32'h0BAD_F00D);
      idle(3, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/memory_unit_queued.md
MEMORY_UNIT_QUEUED -- requirements
Module: memory_unit_queued

Interface
REQ-001 Parameter CORE, default 0, core index for identification.
REQ-002 Parameter DATA_WIDTH, default 32, data width; multiple of 8.
REQ-003 Parameter ADDRESS_BITS, default 20, address width.
REQ-004 Parameter DEPTH, default 4, request-queue entries; power of two, >= 2.
REQ-005 clock  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-low reset (reset==0 resets at the clock edge).
REQ-007 load  input  1  core load request.
REQ-008 store  input  1  core store request.
REQ-009 address  input  ADDRESS_BITS  request address.
REQ-010 store_data  input  DATA_WIDTH  store data.
REQ-011 byte_en  input  DATA_WIDTH/8  store byte enables; ignored for loads.
REQ-012 ready  output  1  queue can accept a request this cycle.
REQ-013 mem_req_valid  output  1  head entry presented downstream.
REQ-014 mem_req_write  output  1  head is a store.
REQ-015 mem_req_addr  output  ADDRESS_BITS  head address.
REQ-016 mem_req_data  output  DATA_WIDTH  head store data.
REQ-017 mem_req_be  output  DATA_WIDTH/8  head byte enables; all-zero for loads.
REQ-018 mem_req_ready  input  1  downstream accepts head.
REQ-019 mem_resp_valid  input  1  downstream load response.
REQ-020 mem_resp_data  input  DATA_WIDTH  load response data.
REQ-021 valid  output  1  one-cycle pulse: load_data/data_addr valid.
REQ-022 data_addr  output  ADDRESS_BITS  address of the completed load.
REQ-023 load_data  output  DATA_WIDTH  completed load data.
REQ-024 load_count, store_count, stall_count  output  32 each  performance counters (see Configuration).

Function
REQ-025 Accept = (load|store) & ready; accepted request is written to the tail entry at the edge; tail advances modulo DEPTH.
REQ-026 load and store both high: treated as a store; load ignored.
REQ-027 ready = (occupancy < DEPTH); occupancy register width clog2(DEPTH)+1.
REQ-028 Full: ready low, no write; push and pop in the same cycle while full is impossible (no push).
REQ-029 Simultaneous push and pop when not full: occupancy unchanged; both pointers advance.
REQ-030 Minimum latency: request accepted in cycle t gives mem_req_valid high in cycle t+1.
REQ-031 mem_req_valid = (occupancy != 0) & !load_pending; mem_req_* driven combinationally from the head entry.
REQ-032 Pop = mem_req_valid & mem_req_ready; head advances modulo DEPTH; mem_req_* are stable while mem_req_valid & !mem_req_ready.
REQ-033 Store pop completes the store; no response is expected.
REQ-034 Load pop sets load_pending and latches the head address; at most one load is outstanding.
REQ-035 While load_pending, mem_resp_valid high: the next cycle gives valid=1, load_data=mem_resp_data, data_addr=latched address; load_pending clears at the same edge.
REQ-036 mem_resp_valid with no load pending is ignored.
REQ-037 Response and a new pop in the same cycle: not possible (REQ-031); the earliest next issue is the cycle after the response edge.
REQ-038 valid is low at all other times; load_data/data_addr hold their last values.
REQ-039 Program order is preserved; no reordering or forwarding.

Reset
REQ-040 reset==0 at an edge: pointers=0, occupancy=0, load_pending=0, valid=0, load_data=0, data_addr=0, counters=0.
REQ-041 Reset mid-operation flushes all queued entries; an outstanding load is abandoned and its late response is ignored.
REQ-042 During reset: ready=0 and mem_req_valid=0.

Configuration
REQ-043 Macro MEM_UNIT_PERF_EN defined: load_count/store_count +1 per accepted load/store; stall_count +1 per cycle with (load|store) & !ready; each counter saturates at 0xFFFFFFFF.
REQ-044 MEM_UNIT_PERF_EN undefined: counter logic is omitted and the three ports are tied to 0.

Verification
REQ-045 DEPTH=4, mem_req_ready=0, 5 back-to-back stores -> ready low after the 4th, 5th rejected, stall_count=1 (PERF_EN).
REQ-046 Load 0x00100, mem_resp_valid 3 cycles after pop with data 0xDEADBEEF -> valid pulses once, data_addr=0x00100, load_data=0xDEADBEEF.
REQ-047 Load then store queued, response delayed 5 cycles -> store is not presented until the cycle after the load response.
REQ-048 load=store=1, address 0x00040 -> one store entry, mem_req_write=1, load_count unchanged.
REQ-049 Reset asserted with 3 queued entries and a pending load; response arrives after reset -> valid stays 0, occupancy 0.
REQ-050 8 pushes/pops with mem_req_ready=1 -> pointer wrap; addresses emerge in order 0..7.
